regfile: RTL and testbench

Architectural general-purpose register file: the consumer end of the MEM/WB write-back interface. Accepts the write-back triple (target register, write enable, data) each cycle and commits it to one of 32 x 32-bit registers. Serves two asynchronous read ports to the ID stage. Emits a registered commit trace for the debug/difftest harness.

---
 rtl/regfile_if.sv | 49 ++++
 rtl/regfile.sv | 87 ++++++++
 tb/tb_regfile.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_if.sv
// regfile_if -- write-back and register-read bundle between the pipeline
// and the architectural register file.
//
// Signal summary:
//   we, waddr[4:0], wdata[31:0]   write-back triple from MEM/WB
//   re1, raddr1[4:0], rdata1[31:0] read port 1 (ID stage)
//   re2, raddr2[4:0], rdata2[31:0] read port 2 (ID stage)
//   debug_wb_we/_waddr/_wdata     registered commit trace for difftest
//
// Handshake semantics: there is no valid/ready pair here. The write-back
// triple is a per-cycle qualifier: when we = 1 at a rising edge, the write
// is accepted unconditionally (the file never back-pressures). Each read
// enable (re1/re2) qualifies its own port combinationally in the same
// cycle; a deasserted enable forces that port's data to zero.
//
// Modports:
//   master - pipeline side, drives write/read requests, observes data/trace
//   slave  - the register file itself
interface regfile_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;

  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  logic        debug_wb_we;
  logic [4:0]  debug_wb_waddr;
  logic [31:0] debug_wb_wdata;

  modport master (
    output we, waddr, wdata,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2,
    input  debug_wb_we, debug_wb_waddr, debug_wb_wdata
  );

  modport slave (
    input  we, waddr, wdata,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2,
    output debug_wb_we, debug_wb_waddr, debug_wb_wdata
  );
endinterface

// File: rtl/regfile.sv
// regfile -- 32 x 32-bit architectural register file, write-back consumer.
//
// Ports:
//   clk  system clock, all state updates on posedge
//   rst  synchronous active-high reset
//   rf   regfile_if.slave: write-back triple, two combinational read
//        ports, and a registered commit trace
//
// Behaviour:
//   - r0 reads as zero and is never written; a write to r0 is a NOP and
//     produces no trace event.
//   - Writes commit on posedge; reads are combinational.
//   - rdata is zero while rst is high, when its enable is low, or when it
//     addresses r0.
//
// Optional feature, macro REGFILE_BYPASS_EN:
//   defined   - a read of the index being written in the same cycle
//               returns the incoming wdata (write-through bypass).
//   undefined - such a read returns the stored, pre-write value; the
//               pipeline is expected to forward or stall.
module regfile (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  rf
);

  logic [31:0] regs [0:31];
  logic        commit;

  // A real architectural commit: enabled and not targeting r0.
  assign commit = rf.we && (rf.waddr != 5'd0);

  // Storage. regs[0] is cleared on reset and never written afterwards,
  // and the read path never returns it anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (commit) begin
      regs[rf.waddr] <= rf.wdata;
    end
  end

  // Commit trace: the strobe follows every cycle, the index/data only
  // update on a real commit so the harness can see the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf.debug_wb_we    <= 1'b0;
      rf.debug_wb_waddr <= 5'd0;
      rf.debug_wb_wdata <= 32'h0;
    end else begin
      rf.debug_wb_we <= commit;
      if (commit) begin
        rf.debug_wb_waddr <= rf.waddr;
        rf.debug_wb_wdata <= rf.wdata;
      end
    end
  end

  // Read port 1.
  always_comb begin
    rf.rdata1 = 32'h0;
    if (!rst && rf.re1 && (rf.raddr1 != 5'd0)) begin
      rf.rdata1 = regs[rf.raddr1];
`ifdef REGFILE_BYPASS_EN
      if (commit && (rf.raddr1 == rf.waddr)) begin
        rf.rdata1 = rf.wdata;
      end
`endif
    end
  end

  // Read port 2, identical to port 1 and fully independent of it.
  always_comb begin
    rf.rdata2 = 32'h0;
    if (!rst && rf.re2 && (rf.raddr2 != 5'd0)) begin
      rf.rdata2 = regs[rf.raddr2];
`ifdef REGFILE_BYPASS_EN
      if (commit && (rf.raddr2 == rf.waddr)) begin
        rf.rdata2 = rf.wdata;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile -- directed self-checking bench for regfile.
// Inputs change just after a falling edge; combinational reads are sampled
// 1 time unit later, registered outputs after the following rising edge.
module tb_regfile;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_if rf_if ();

  regfile dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    rf_if.we     = 1'b0;
    rf_if.waddr  = 5'd0;
    rf_if.wdata  = 32'h0;
    rf_if.re1    = 1'b0;
    rf_if.raddr1 = 5'd0;
    rf_if.re2    = 1'b0;
    rf_if.raddr2 = 5'd0;
  endtask

  task automatic drive_write(input logic [4:0] a, input logic [31:0] d);
    rf_if.we    = 1'b1;
    rf_if.waddr = a;
    rf_if.wdata = d;
  endtask

  task automatic drive_read(input logic e1, input logic [4:0] a1,
                            input logic e2, input logic [4:0] a2);
    rf_if.re1    = e1;
    rf_if.raddr1 = a1;
    rf_if.re2    = e2;
    rf_if.raddr2 = a2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    drive_read(1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    n_checks++;
    if (rf_if.debug_wb_we !== 1'b0 || rf_if.debug_wb_waddr !== 5'd0 ||
        rf_if.debug_wb_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_trace we=%b waddr=%0d wdata=%h required 0/0/0",
               rf_if.debug_wb_we, rf_if.debug_wb_waddr, rf_if.debug_wb_wdata);
    end
    rst = 1'b0;
    drive_write(5'd5, 32'hDEADBEEF);
    tick();
    rf_if.we = 1'b0;
    #1;
    n_checks++;
    if (rf_if.rdata1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL reset_prewrite rdata1=%h required DEADBEEF", rf_if.rdata1);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (rf_if.rdata1 !== 32'h0 || rf_if.rdata2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_read_forced rdata1=%h rdata2=%h required 0", rf_if.rdata1, rf_if.rdata2);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (rf_if.rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_clear_r5 rdata1=%h required 00000000", rf_if.rdata1);
    end
    n_checks++;
    if (rf_if.debug_wb_we !== 1'b0 || rf_if.debug_wb_waddr !== 5'd0 ||
        rf_if.debug_wb_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_clear_trace we=%b waddr=%0d wdata=%h required 0/0/0",
               rf_if.debug_wb_we, rf_if.debug_wb_waddr, rf_if.debug_wb_wdata);
    end
  endtask

  task automatic test_basic_write();
    drive_idle();
    drive_write(5'd3, 32'h12345678);
    tick();
    rf_if.we = 1'b0;
    drive_read(1'b1, 5'd3, 1'b0, 5'd0);
    #1;
    n_checks++;
    if (rf_if.rdata1 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL basic_read rdata1=%h required 12345678", rf_if.rdata1);
    end
    n_checks++;
    if (rf_if.debug_wb_we !== 1'b1 || rf_if.debug_wb_waddr !== 5'd3 ||
        rf_if.debug_wb_wdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL basic_trace we=%b waddr=%0d wdata=%h required 1/3/12345678",
               rf_if.debug_wb_we, rf_if.debug_wb_waddr, rf_if.debug_wb_wdata);
    end
    tick();
    #1;
    n_checks++;
    if (rf_if.debug_wb_we !== 1'b0 || rf_if.debug_wb_waddr !== 5'd3 ||
        rf_if.debug_wb_wdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL basic_trace_hold we=%b waddr=%0d wdata=%h required 0/3/12345678",
               rf_if.debug_wb_we, rf_if.debug_wb_waddr, rf_if.debug_wb_wdata);
    end
  endtask

  task automatic test_r0_immutable();
    drive_idle();
    drive_write(5'd0, 32'hFFFFFFFF);
    drive_read(1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    n_checks++;
    if (rf_if.rdata1 !== 32'h0 || rf_if.rdata2 !== 32'h0) begin
      n_fail++;
      $display("FAIL r0_same_cycle rdata1=%h rdata2=%h required 0", rf_if.rdata1, rf_if.rdata2);
    end
    tick();
    rf_if.we = 1'b0;
    #1;
    n_checks++;
    if (rf_if.rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL r0_after rdata1=%h required 0", rf_if.rdata1);
    end
    n_checks++;
    if (rf_if.debug_wb_we !== 1'b0 || rf_if.debug_wb_waddr !== 5'd3 ||
        rf_if.debug_wb_wdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL r0_trace we=%b waddr=%0d wdata=%h required 0/3/12345678",
               rf_if.debug_wb_we, rf_if.debug_wb_waddr, rf_if.debug_wb_wdata);
    end
  endtask

  task automatic test_hazard();
    logic [31:0] exp_same;
    drive_idle();
    drive_write(5'd7, 32'h1);
    tick();
    drive_write(5'd7, 32'h2);
    drive_read(1'b1, 5'd7, 1'b1, 5'd7);
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h2;
`else
    exp_same = 32'h1;
`endif
    #1;
    n_checks++;
    if (rf_if.rdata1 !== exp_same || rf_if.rdata2 !== exp_same) begin
      n_fail++;
      $display("FAIL hazard_same_cycle rdata1=%h rdata2=%h required %h",
               rf_if.rdata1, rf_if.rdata2, exp_same);
    end
    tick();
    rf_if.we = 1'b0;
    #1;
    n_checks++;
    if (rf_if.rdata1 !== 32'h2 || rf_if.rdata2 !== 32'h2) begin
      n_fail++;
      $display("FAIL hazard_next_cycle rdata1=%h rdata2=%h required 2", rf_if.rdata1, rf_if.rdata2);
    end
    n_checks++;
    if (rf_if.debug_wb_we !== 1'b1 || rf_if.debug_wb_waddr !== 5'd7 ||
        rf_if.debug_wb_wdata !== 32'h2) begin
      n_fail++;
      $display("FAIL hazard_trace we=%b waddr=%0d wdata=%h required 1/7/2",
               rf_if.debug_wb_we, rf_if.debug_wb_waddr, rf_if.debug_wb_wdata);
    end
  endtask

  task automatic test_read_enable();
    drive_idle();
    drive_write(5'd9, 32'hA5A5A5A5);
    tick();
    rf_if.we = 1'b0;
    drive_read(1'b0, 5'd9, 1'b0, 5'd9);
    #1;
    n_checks++;
    if (rf_if.rdata1 !== 32'h0 || rf_if.rdata2 !== 32'h0) begin
      n_fail++;
      $display("FAIL re_disabled rdata1=%h rdata2=%h required 0", rf_if.rdata1, rf_if.rdata2);
    end
    rf_if.re2 = 1'b1;
    #1;
    n_checks++;
    if (rf_if.rdata2 !== 32'hA5A5A5A5 || rf_if.rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL re2_enabled rdata2=%h rdata1=%h required A5A5A5A5/0", rf_if.rdata2, rf_if.rdata1);
    end
    // Ports are independent: different indices at once.
    drive_read(1'b1, 5'd7, 1'b1, 5'd9);
    #1;
    n_checks++;
    if (rf_if.rdata1 !== 32'h2 || rf_if.rdata2 !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL dual_port rdata1=%h rdata2=%h required 2/A5A5A5A5", rf_if.rdata1, rf_if.rdata2);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] vals [3];
    logic [31:0] exp;
    vals[0] = 32'h0000000A;
    vals[1] = 32'h0000000B;
    vals[2] = 32'h0000000C;
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      drive_write(5'd31, vals[i]);
      exp_q.push_back(vals[i]);
      tick();
      #1;
      exp = exp_q.pop_front();
      n_checks++;
      if (rf_if.debug_wb_we !== 1'b1 || rf_if.debug_wb_waddr !== 5'd31 ||
          rf_if.debug_wb_wdata !== exp) begin
        n_fail++;
        $display("FAIL b2b_trace_%0d we=%b waddr=%0d wdata=%h required 1/31/%h",
                 i, rf_if.debug_wb_we, rf_if.debug_wb_waddr, rf_if.debug_wb_wdata, exp);
      end
    end
    rf_if.we = 1'b0;
    drive_read(1'b1, 5'd31, 1'b1, 5'd31);
    #1;
    n_checks++;
    if (rf_if.rdata1 !== 32'hC || rf_if.rdata2 !== 32'hC) begin
      n_fail++;
      $display("FAIL b2b_last_wins rdata1=%h rdata2=%h required C", rf_if.rdata1, rf_if.rdata2);
    end
  endtask

  task automatic test_reset_collision();
    drive_idle();
    drive_write(5'd4, 32'h11);
    tick();
    drive_write(5'd4, 32'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_idle();
    drive_read(1'b1, 5'd4, 1'b1, 5'd9);
    #1;
    n_checks++;
    if (rf_if.rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL collision_r4 rdata1=%h required 0", rf_if.rdata1);
    end
    n_checks++;
    if (rf_if.rdata2 !== 32'h0) begin
      n_fail++;
      $display("FAIL collision_r9_cleared rdata2=%h required 0", rf_if.rdata2);
    end
    n_checks++;
    if (rf_if.debug_wb_we !== 1'b0 || rf_if.debug_wb_waddr !== 5'd0 ||
        rf_if.debug_wb_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL collision_trace we=%b waddr=%0d wdata=%h required 0/0/0",
               rf_if.debug_wb_we, rf_if.debug_wb_waddr, rf_if.debug_wb_wdata);
    end
    tick();
    #1;
    n_checks++;
    if (rf_if.debug_wb_we !== 1'b0 || rf_if.rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL collision_after we=%b rdata1=%h required 0/0", rf_if.debug_wb_we, rf_if.rdata1);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive_idle();
    test_reset();
    test_basic_write();
    test_r0_immutable();
    test_hazard();
    test_read_enable();
    test_back_to_back();
    test_reset_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
